// File: rtl/prog_mod_cntr_pkg.sv
// Shared types and constants for the programmable-modulus counter.
package prog_mod_cntr_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MIN_MOD = 2;

endpackage

// File: rtl/prog_mod_cntr_wrap_stat.sv
// Saturating event counter: counts i_inc pulses, sticks at all-ones.
// Clear wins over a same-cycle increment.
module wrap_stat_cntr #(
  parameter int STAT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_inc,
  input  logic              i_clr,
  output logic [STAT_W-1:0] o_cnt
);

  localparam logic [STAT_W-1:0] ONE = STAT_W'(1);

  logic [STAT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/prog_mod_cntr.sv
// Up/down counter with runtime modulus (shadowed, applied at safe points),
// load, wrap/saturate modes, cascadable terminal count and wrap statistics.
module prog_mod_cntr
  import prog_mod_cntr_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_MOD = 6,
  parameter int STAT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_up_down,
  input  logic              i_mode,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_load_val,
  input  logic              i_mod_wr,
  input  logic [WIDTH-1:0]  i_mod_val,
  input  logic              i_clr,
  output logic [WIDTH-1:0]  o_Q,
  output logic              o_tc,
  output logic              o_wrap,
  output logic [WIDTH-1:0]  o_mod,
  output logic              o_mod_pend,
  output logic [STAT_W-1:0] o_wrap_cnt,
  output logic              o_err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  mode_e            w_mode;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_mod;
  logic [WIDTH-1:0] r_pend_val;
  logic             r_pend_vld;
  logic             r_wrap;
  logic             r_err;

  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_mod_eff;
  logic [WIDTH-1:0] w_top_eff;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_at_top;
  logic             w_at_bot;
  logic             w_wrap_evt;
  logic             w_apply;
  logic             w_mod_ok;
  logic             w_err_set;

  assign w_mode   = mode_e'(i_mode);
  assign w_top    = r_mod - ONE;
  assign w_at_top = (r_q == w_top);
  assign w_at_bot = (r_q == '0);

  // Wrap detection uses the modulus currently in force; the destination of a
  // down-wrap uses the modulus being applied on this same edge.
  assign w_wrap_evt = i_en && !i_load && (w_mode == MODE_WRAP) &&
                      ((i_up_down == DIR_UP) ? w_at_top : w_at_bot);
  assign w_apply    = r_pend_vld && (i_load || !i_en || w_wrap_evt);
  assign w_mod_eff  = w_apply ? r_pend_val : r_mod;
  assign w_top_eff  = w_mod_eff - ONE;
  assign w_mod_ok   = (i_mod_val >= WIDTH'(MIN_MOD));

  always_comb begin
    w_q_nxt   = r_q;
    w_err_set = 1'b0;
    if (i_load) begin
      if (i_load_val < w_mod_eff) begin
        w_q_nxt = i_load_val;
      end else begin
        w_q_nxt   = w_top_eff;
        w_err_set = 1'b1;
      end
    end else if (i_en) begin
      if (i_up_down == DIR_UP) begin
        if (!w_at_top)                w_q_nxt = r_q + ONE;
        else if (w_mode == MODE_WRAP) w_q_nxt = '0;
      end else begin
        if (!w_at_bot)                w_q_nxt = r_q - ONE;
        else if (w_mode == MODE_WRAP) w_q_nxt = w_top_eff;
      end
    end else if (w_apply && (r_q >= w_mod_eff)) begin
      w_q_nxt = w_top_eff;
    end
    if (i_mod_wr && !w_mod_ok) w_err_set = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q        <= '0;
      r_mod      <= WIDTH'(DEFAULT_MOD);
      r_pend_val <= '0;
      r_pend_vld <= 1'b0;
      r_wrap     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_wrap <= w_wrap_evt;
      if (w_apply) r_mod <= r_pend_val;
      // A fresh write always lands in the shadow, even when the old one applies now.
      if (i_mod_wr && w_mod_ok) begin
        r_pend_val <= i_mod_val;
        r_pend_vld <= 1'b1;
      end else if (w_apply) begin
        r_pend_vld <= 1'b0;
      end
      if (i_clr)          r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
    end
  end

  wrap_stat_cntr #(
    .STAT_W (STAT_W)
  ) u_wrap_stat (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_wrap_evt),
    .i_clr   (i_clr),
    .o_cnt   (o_wrap_cnt)
  );

  assign o_Q        = r_q;
  assign o_tc       = (i_up_down == DIR_UP) ? w_at_top : w_at_bot;
  assign o_wrap     = r_wrap;
  assign o_mod      = r_mod;
  assign o_mod_pend = r_pend_vld;
  assign o_err      = r_err;

endmodule

// File: tb/tb_prog_mod_cntr.sv
// Scoreboard bench for prog_mod_cntr: directed scenarios, random traffic, reset, cascade.
module tb_prog_mod_cntr;
  import prog_mod_cntr_pkg::*;

  localparam int WIDTH  = 8;
  localparam int DEFM   = 6;
  localparam int STAT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, en, up_down, mode, load, mod_wr, clr;
  logic [WIDTH-1:0]  load_val, mod_val;
  logic [WIDTH-1:0]  o_q, o_mod;
  logic              o_tc, o_wrap, o_mod_pend, o_err;
  logic [STAT_W-1:0] o_wrap_cnt;

  prog_mod_cntr #(.WIDTH(WIDTH), .DEFAULT_MOD(DEFM), .STAT_W(STAT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_up_down(up_down), .i_mode(mode),
    .i_load(load), .i_load_val(load_val), .i_mod_wr(mod_wr), .i_mod_val(mod_val),
    .i_clr(clr), .o_Q(o_q), .o_tc(o_tc), .o_wrap(o_wrap), .o_mod(o_mod),
    .o_mod_pend(o_mod_pend), .o_wrap_cnt(o_wrap_cnt), .o_err(o_err)
  );

  // Two-digit decimal cascade
  logic              c_rst_n, c_en;
  logic [WIDTH-1:0]  lo_q, hi_q, lo_mod, hi_mod;
  logic              lo_tc, hi_tc, lo_wrap, hi_wrap, lo_pend, hi_pend, lo_err, hi_err;
  logic [STAT_W-1:0] lo_wcnt, hi_wcnt;

  prog_mod_cntr #(.WIDTH(WIDTH), .DEFAULT_MOD(10), .STAT_W(STAT_W)) u_lo (
    .i_clk(clk), .i_rst_n(c_rst_n), .i_en(c_en), .i_up_down(1'b1), .i_mode(1'b0),
    .i_load(1'b0), .i_load_val(8'd0), .i_mod_wr(1'b0), .i_mod_val(8'd0),
    .i_clr(1'b0), .o_Q(lo_q), .o_tc(lo_tc), .o_wrap(lo_wrap), .o_mod(lo_mod),
    .o_mod_pend(lo_pend), .o_wrap_cnt(lo_wcnt), .o_err(lo_err)
  );

  prog_mod_cntr #(.WIDTH(WIDTH), .DEFAULT_MOD(10), .STAT_W(STAT_W)) u_hi (
    .i_clk(clk), .i_rst_n(c_rst_n), .i_en(c_en & lo_tc), .i_up_down(1'b1), .i_mode(1'b0),
    .i_load(1'b0), .i_load_val(8'd0), .i_mod_wr(1'b0), .i_mod_val(8'd0),
    .i_clr(1'b0), .o_Q(hi_q), .o_tc(hi_tc), .o_wrap(hi_wrap), .o_mod(hi_mod),
    .o_mod_pend(hi_pend), .o_wrap_cnt(hi_wcnt), .o_err(hi_err)
  );

  typedef struct {
    int q; int wrap; int mod; int pend; int wcnt; int err; int tc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_q, m_mod, m_pval, m_wcnt, m_err, m_wrap;
  bit m_pvld;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_mod = DEFM; m_pval = 0; m_pvld = 0;
    m_wcnt = 0; m_err = 0; m_wrap = 0;
  endtask

  task automatic model_step(input bit e, input bit up, input bit sat, input bit ld,
                            input int lv, input bit mw, input int mv, input bit cl);
    bit wrap_ev, apply, err_set;
    int m_new;
    err_set = 0;
    wrap_ev = e && !ld && !sat && (up ? (m_q + 1 == m_mod) : (m_q == 0));
    apply   = m_pvld && (ld || !e || wrap_ev);
    m_new   = apply ? m_pval : m_mod;
    if (ld) begin
      if (lv < m_new) m_q = lv;
      else begin m_q = m_new - 1; err_set = 1; end
    end else if (e && up) begin
      m_q = sat ? ((m_q + 1 < m_mod) ? m_q + 1 : m_mod - 1) : (m_q + 1) % m_mod;
    end else if (e) begin
      m_q = (m_q > 0) ? m_q - 1 : (sat ? 0 : m_new - 1);
    end else if (m_q >= m_new) begin
      m_q = m_new - 1;
    end
    m_mod = m_new;
    if (apply) m_pvld = 0;
    if (mw) begin
      if (mv >= MIN_MOD) begin m_pvld = 1; m_pval = mv; end
      else err_set = 1;
    end
    m_wrap = wrap_ev;
    m_wcnt = cl ? 0 : ((wrap_ev && m_wcnt < (1 << STAT_W) - 1) ? m_wcnt + 1 : m_wcnt);
    m_err  = cl ? 0 : (m_err | err_set);
  endtask

  // One clock of stimulus; expected post-edge state goes to the scoreboard.
  task automatic cyc(input bit e, input bit up, input bit sat, input bit ld,
                     input int lv, input bit mw, input int mv, input bit cl);
    exp_t x;
    @(negedge clk);
    en = e; up_down = up; mode = sat; load = ld; load_val = WIDTH'(lv);
    mod_wr = mw; mod_val = WIDTH'(mv); clr = cl;
    model_step(e, up, sat, ld, lv, mw, mv, cl);
    x.q = m_q; x.wrap = m_wrap; x.mod = m_mod; x.pend = int'(m_pvld);
    x.wcnt = m_wcnt; x.err = m_err;
    x.tc = up ? int'(m_q == m_mod - 1) : int'(m_q == 0);
    sb.push_back(x);
  endtask

  task automatic idle_inputs();
    en = 0; up_down = 1; mode = 0; load = 0; load_val = '0;
    mod_wr = 0; mod_val = '0; clr = 0;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("q",      o_q,        mon_e.q);
      chk("tc",     o_tc,       mon_e.tc);
      chk("wrap",   o_wrap,     mon_e.wrap);
      chk("mod",    o_mod,      mon_e.mod);
      chk("pend",   o_mod_pend, mon_e.pend);
      chk("wcnt",   o_wrap_cnt, mon_e.wcnt);
      chk("err",    o_err,      mon_e.err);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; c_rst_n = 0; c_en = 0;
    idle_inputs();
    model_reset();
    #12;
    chk("rst_q",    o_q,        0);
    chk("rst_mod",  o_mod,      DEFM);
    chk("rst_pend", o_mod_pend, 0);
    chk("rst_wrap", o_wrap,     0);
    chk("rst_wcnt", o_wrap_cnt, 0);
    chk("rst_err",  o_err,      0);
    chk("rst_tc",   o_tc,       0);
    @(negedge clk);
    rst_n = 1;

    // Up count through one wrap at M=6
    for (int i = 0; i < 7; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
    // Saturating down count from load 2
    cyc(0, 0, 1, 1, 2, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 0, 0, 0, 0);
    // Modulus write 10 at Q=3 while counting up
    cyc(0, 1, 0, 1, 3, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 1, 10, 0);
    for (int i = 0; i < 13; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
    // Illegal modulus, then clear
    cyc(1, 1, 0, 0, 0, 1, 1, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 1);
    // Back to M=6 via idle apply, then over-range load and load-beats-enable
    cyc(0, 1, 0, 0, 0, 1, 6, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 7, 0, 0, 0);
    cyc(1, 1, 0, 1, 3, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 1);
    // Write and apply in the same cycle; idle apply clamps Q
    cyc(1, 1, 0, 0, 0, 1, 8, 0);
    cyc(0, 1, 0, 0, 0, 1, 4, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    // Down-wrap with a pending modulus lands on the new M-1
    cyc(0, 0, 0, 1, 0, 1, 9, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 9) == 0), $urandom_range(0, 20),
          ($urandom_range(0, 7) == 0), $urandom_range(0, 15),
          ($urandom_range(0, 29) == 0));
    end

    // Asynchronous reset mid-count
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 0;
    idle_inputs();
    #1;
    chk("mid_rst_q",    o_q,        0);
    chk("mid_rst_mod",  o_mod,      DEFM);
    chk("mid_rst_pend", o_mod_pend, 0);
    chk("mid_rst_wrap", o_wrap,     0);
    chk("mid_rst_wcnt", o_wrap_cnt, 0);
    chk("mid_rst_err",  o_err,      0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0);

    // Cascade 00..99 and beyond
    @(negedge clk);
    c_rst_n = 1;
    c_en = 1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      chk("casc_lo", lo_q, k % 10);
      chk("casc_hi", hi_q, (k / 10) % 10);
    end

    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
